// File: rtl/seq_event_capture_pkg.sv
// Shared constants and types for the sequence-event capture block.
// The package is named seq_evt_pkg and is imported by every other file in this slice.
package seq_evt_pkg;

    localparam int TS_W_DEF    = 16;
    localparam int CNT_W_DEF   = 16;
    localparam int DEPTH_DEF   = 8;
    localparam int DROP_W      = 8;
    localparam int HOLDOFF_DEF = 4;

    typedef logic [TS_W_DEF-1:0] ts_t;

endpackage

// File: rtl/seq_event_capture_if.sv
// Valid/ready event-readout channel.
// The capture block drives the channel through the master modport; the reader uses the slave modport.
interface seq_event_capture_if
    import seq_evt_pkg::*;
#(
    parameter int TS_W = TS_W_DEF
);

    logic            evt_valid;
    logic            evt_ready;
    logic [TS_W-1:0] evt_ts;

    modport master (
        output evt_valid,
        output evt_ts,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ts,
        output evt_ready
    );

endinterface

// File: rtl/seq_event_capture_fifo.sv
// Synchronous show-ahead FIFO used to buffer event timestamps (module seq_evt_fifo).
// The pointers carry one extra wrap bit, so full and empty come from comparing the pointers.
module seq_evt_fifo
    import seq_evt_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         wr_en;
    logic         rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // When the FIFO is full, a push is still accepted if the head entry is popped in the same cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/seq_event_capture.sv
// Timestamps rising edges of seq_found, buffers the stamps and keeps saturating event and drop counts.
// Optional build macro SEQ_EVT_HOLDOFF_EN: ignore edges for HOLDOFF-1 cycles after each accepted event.
module seq_event_capture
    import seq_evt_pkg::*;
#(
    parameter int TS_W    = TS_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       seq_found,
    input  logic                       clear,
    seq_event_capture_if.master        evt_if,
    output logic [CNT_W-1:0]           evt_count,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       fifo_full,
    output logic                       fifo_empty
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLDOFF < 1) begin : g_param_err
        $error("seq_event_capture: DEPTH must be a power of two >= 2 and HOLDOFF >= 1");
    end

    logic [TS_W-1:0] ts;
    logic            prev;
    logic            edge_det;
    logic            evt_fire;
    logic            evt_take;
    logic            push;
    logic            pop;
    logic            drop;

    always_ff @(posedge clk) begin
        if (rst_n) ts <= '0;
        else       ts <= ts + 1'b1;
    end

    // prev keeps following seq_found during clear, so an input level held high across a clear is not counted again.
    always_ff @(posedge clk) begin
        if (rst_n) prev <= 1'b0;
        else       prev <= seq_found;
    end

    assign edge_det = seq_found && !prev;

`ifdef SEQ_EVT_HOLDOFF_EN
    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [HO_W-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (rst_n || clear)      hold_cnt <= '0;
        else if (evt_fire)       hold_cnt <= HO_W'(HOLDOFF - 1);
        else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end

    assign evt_fire = edge_det && (hold_cnt == '0);
`else
    assign evt_fire = edge_det;
`endif

    assign evt_take = evt_fire && !clear;
    assign pop      = evt_if.evt_valid && evt_if.evt_ready;
    assign push     = evt_take && (!fifo_full || pop);
    assign drop     = evt_take && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            evt_count <= '0;
        end else if (evt_take && evt_count != '1) begin
            evt_count <= evt_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            drop_count <= '0;
        end else if (drop && drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    seq_evt_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (ts),
        .dout  (evt_if.evt_ts),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_if.evt_valid = !fifo_empty;

endmodule

// File: tb/tb_seq_event_capture.sv
// Directed bench for seq_event_capture: expected stamps go into a queue and a negedge monitor checks every pop.
module tb_seq_event_capture;
    import seq_evt_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 seq_found = 1'b0;
    logic                 clear = 1'b0;
    logic [CNT_W_DEF-1:0] evt_count;
    logic [DROP_W-1:0]    drop_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    seq_event_capture_if #(.TS_W(TS_W_DEF)) evt_if ();

    seq_event_capture #(
        .TS_W    (TS_W_DEF),
        .DEPTH   (DEPTH_DEF),
        .CNT_W   (CNT_W_DEF),
        .HOLDOFF (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seq_found  (seq_found),
        .clear      (clear),
        .evt_if     (evt_if),
        .evt_count  (evt_count),
        .drop_count (drop_count),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    ts_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no entry", evt_if.evt_ts);
            end else begin
                chk("pop_ts", 32'(evt_if.evt_ts), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next();
    endtask

    // Cycle 0 is the first cycle after release, the cycle in which ts reads 0.
    task automatic do_reset();
        rst_n = 1'b1;
        next();
        next();
        exp_q.delete();
        rst_n = 1'b0;
        cyc = 0;
    endtask

    task automatic pulse(input int c, input bit expect_entry);
        goto(c);
        seq_found = 1'b1;
        if (expect_entry) exp_q.push_back(ts_t'(c));
        next();
        seq_found = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        evt_if.evt_ready = 1'b1;
        while (!fifo_empty && n < 20) begin
            next();
            n++;
        end
        chk({name, "_empty"}, 32'(fifo_empty), 32'd1);
        chk({name, "_q_left"}, 32'(exp_q.size()), 32'd0);
        evt_if.evt_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        evt_if.evt_ready = 1'b0;
        next();
        @(negedge clk);
        chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("rst_ts", 32'(evt_if.evt_ts), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);

        // A level held high for cycles 5..7 counts once.
        do_reset();
        goto(5);
        seq_found = 1'b1;
        exp_q.push_back(ts_t'(5));
        goto(6);
        @(negedge clk);
        chk("t1_valid", 32'(evt_if.evt_valid), 32'd1);
        chk("t1_ts", 32'(evt_if.evt_ts), 32'd5);
        chk("t1_count", 32'(evt_count), 32'd1);
        goto(8);
        seq_found = 1'b0;
        drain("t1");
        chk("t1_level_once", 32'(evt_count), 32'd1);

`ifndef SEQ_EVT_HOLDOFF_EN
        // Nine pulses into an eight-entry FIFO: the ninth is dropped.
        do_reset();
        for (int i = 0; i < 9; i++) pulse(2 + 2 * i, i < 8);
        goto(19);
        @(negedge clk);
        chk("t2_full", 32'(fifo_full), 32'd1);
        chk("t2_drop", 32'(drop_count), 32'd1);
        chk("t2_count", 32'(evt_count), 32'd9);
        drain("t2");

        // FIFO full, and a pulse arrives in the same cycle as a pop.
        do_reset();
        for (int i = 0; i < 8; i++) pulse(2 + 2 * i, 1'b1);
        goto(17);
        @(negedge clk);
        chk("t3_full_before", 32'(fifo_full), 32'd1);
        goto(20);
        seq_found = 1'b1;
        evt_if.evt_ready = 1'b1;
        exp_q.push_back(ts_t'(20));
        next();
        seq_found = 1'b0;
        evt_if.evt_ready = 1'b0;
        @(negedge clk);
        chk("t3_full_after", 32'(fifo_full), 32'd1);
        chk("t3_drop", 32'(drop_count), 32'd0);
        chk("t3_count", 32'(evt_count), 32'd9);
        drain("t3");

        // Clear together with an edge, then reset in the middle of a drain.
        do_reset();
        for (int i = 0; i < 3; i++) pulse(2 + 2 * i, 1'b1);
        goto(8);
        seq_found = 1'b1;
        clear = 1'b1;
        exp_q.delete();
        next();
        clear = 1'b0;
        @(negedge clk);
        chk("t5_clr_empty", 32'(fifo_empty), 32'd1);
        chk("t5_clr_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("t5_clr_count", 32'(evt_count), 32'd0);
        chk("t5_clr_drop", 32'(drop_count), 32'd0);
        next();
        seq_found = 1'b0;
        @(negedge clk);
        chk("t5_prev_updated", 32'(fifo_empty), 32'd1);
        pulse(12, 1'b1);
        pulse(14, 1'b1);
        pulse(16, 1'b1);
        goto(18);
        evt_if.evt_ready = 1'b1;
        next();
        rst_n = 1'b1;
        next();
        @(negedge clk);
        chk("t5_rst_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("t5_rst_ts", 32'(evt_if.evt_ts), 32'd0);
        chk("t5_rst_count", 32'(evt_count), 32'd0);
        chk("t5_rst_drop", 32'(drop_count), 32'd0);
        chk("t5_rst_full", 32'(fifo_full), 32'd0);
        chk("t5_rst_empty", 32'(fifo_empty), 32'd1);
        evt_if.evt_ready = 1'b0;

        // Timestamp wrap: stamps 0xFFFF and then 0x0001.
        do_reset();
        pulse(65535, 1'b1);
        pulse(65537, 1'b1);
        goto(65539);
        @(negedge clk);
        chk("t4_count", 32'(evt_count), 32'd2);
        drain("t4");
`else
        // Holdoff of 4 cycles: the edge at cycle 12 is ignored.
        do_reset();
        pulse(10, 1'b1);
        pulse(12, 1'b0);
        pulse(14, 1'b1);
        goto(16);
        @(negedge clk);
        chk("t6_count", 32'(evt_count), 32'd2);
        chk("t6_drop", 32'(drop_count), 32'd0);
        drain("t6");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_event_capture.md
# seq_event_capture

Downstream consumer of the sequence detector's `seq_found` output. It detects each rising edge of `seq_found` and stamps it with a free-running cycle timestamp. The stamp is buffered in a small FIFO and presented to a reader over a valid/ready handshake. The block also keeps saturating counts of detected and dropped events for status readout.

## Interface
Parameters:
- TS_W, 16, timestamp width; counter wraps modulo 2^TS_W
- DEPTH, 8, FIFO entries; power of two, ≥2
- CNT_W, 16, event counter width
- HOLDOFF, 4, minimum cycles between accepted events; used only when the holdoff feature is compiled in

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-high (asserted = 1)
- seq_found  in  1  detector output, level or pulse
- clear  in  1  synchronous flush of FIFO and counters
- evt_valid  out  1  head FIFO entry available
- evt_ready  in  1  reader accepts head entry
- evt_ts  out  TS_W  timestamp of head entry; 0 when empty
- evt_count  out  CNT_W  detected edges, saturating
- drop_count  out  8  edges lost to full FIFO, saturating at 255
- fifo_full  out  1  occupancy == DEPTH
- fifo_empty  out  1  occupancy == 0

## Operation
- Timestamp `ts`:
  - Held at 0 while rst_n = 1.
  - Reads 0 in the first cycle after release, then increments by 1 per cycle and wraps.
  - Unaffected by `clear`.
- Edge detect:
  - Register `prev` samples `seq_found`; reset value 0.
  - An event occurs when `seq_found` = 1 and `prev` = 0.
  - A level held high counts once.
- Push on event:
  - The write stores the current `ts` value.
  - `evt_count` increments and saturates at 2^CNT_W − 1.
- Full FIFO:
  - Full with no pop in the same cycle: the event is dropped and `drop_count` increments; `evt_count` still increments.
  - Full with a pop in the same cycle: the push is accepted and occupancy stays at DEPTH.
- Pop occurs when `evt_valid` && `evt_ready`. Read is show-ahead: `evt_ts` shows the head entry combinationally from the registered storage.
- Empty FIFO: `evt_valid` = 0, and `evt_ready` is ignored.
- `clear`:
  - Empties the FIFO and zeroes `evt_count` and `drop_count`.
  - An event in the same cycle is discarded (clear wins).
  - `prev` still updates.
- Reset mid-operation: all state returns to reset values on the next edge; in-flight entries are lost.
- Reset values: evt_valid 0, evt_ts 0, evt_count 0, drop_count 0, fifo_full 0, fifo_empty 1.

## Timing
- Event detected in cycle N (edge at end of N): `evt_valid` = 1 in cycle N+1 with `evt_ts` = ts(N). Latency is 1 cycle.
- Back-to-back pulses, high–low–high: two entries with stamps differing by 2.
- Throughput: one push and one pop per cycle; occupancy unchanged on a simultaneous push+pop.
- Status outputs are registered and reflect post-edge state:
  - `fifo_full`, `fifo_empty`, `evt_count` and `drop_count` update in the same cycle the entry becomes visible.
- Pointers are log2(DEPTH)+1 bits; full/empty are derived from the MSB compare, so wrap needs no special case.

## Configuration
- Macro `SEQ_EVT_HOLDOFF_EN`.
- Defined:
  - After an accepted event, a down-counter loads HOLDOFF−1.
  - Edges while the counter is nonzero are ignored: not pushed, not counted in either counter.
  - The counter clears on reset and on `clear`.
- Undefined: every edge is an event, HOLDOFF is unused, and no holdoff logic is synthesized.

## Structure
- Package `seq_evt_pkg` holds the default TS_W, CNT_W and DEPTH constants, the drop-counter width (8) and a `ts_t` typedef.
- One sub-module, `seq_evt_fifo`: a parameterized synchronous show-ahead FIFO (push, pop, data in/out, full, empty, clear).
- Edge detect, timestamp, counters and holdoff live in the top level.

## Test plan
- Release reset; hold seq_found = 1 for cycles 5–7 → one entry, evt_valid = 1 in cycle 6, evt_ts = 5, evt_count = 1.
- evt_ready = 0; nine pulses spaced by 2 cycles with DEPTH = 8 → fifo_full = 1, drop_count = 1, evt_count = 9; drain 8 entries with stamps in ascending order.
- FIFO full; pulse coincides with pop → occupancy stays 8, drop_count = 0, newest stamp lands last.
- Let ts run past 0xFFFF; pulse at ts = 0xFFFF and again 2 cycles later → stamps 0xFFFF then 0x0001.
- FIFO holds 3 entries; assert clear together with an edge → fifo_empty = 1, counters 0, no entry; assert rst_n mid-drain → all outputs return to reset values next cycle.
- With SEQ_EVT_HOLDOFF_EN and HOLDOFF = 4, pulses at cycles 10, 12 and 14 → entries for 10 and 14 only, evt_count = 2.
